// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-ported data memory: the CPU MEM stage has priority, while a
// starvation counter and a locked-burst cap make sure the DMA/loader side also gets memory cycles.
module dmem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          cpu_req,
  input  logic [3:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic [3:0]    dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
);

  localparam int WCW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int BCW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIM  = WCW'(STARVE_LIMIT);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST_MAX);

  typedef enum logic {CPU_OWN = 1'b0, DMA_OWN = 1'b1} state_e;

  state_e         state_r, state_nxt_s;
  logic [WCW-1:0] wait_cnt_r, wait_nxt_s;
  logic [BCW-1:0] burst_cnt_r, burst_nxt_s;
  logic           cpu_gnt_s, dma_gnt_s, forced_s, wait_at_lim_s, burst_at_max_s;

  assign wait_at_lim_s  = (wait_cnt_r == WAIT_LIM);
  assign burst_at_max_s = (burst_cnt_r == BURST_LIM);
  assign forced_s       = cpu_req & burst_at_max_s;

  // Arbitration and next-state; grants are held low for the whole reset cycle.
  always_comb begin
    cpu_gnt_s   = 1'b0;
    dma_gnt_s   = 1'b0;
    state_nxt_s = state_r;
    burst_nxt_s = burst_cnt_r;
    if (Reset) begin
      state_nxt_s = CPU_OWN;
      burst_nxt_s = '0;
    end else begin
      case (state_r)
        CPU_OWN: begin
          if (cpu_req && !(dma_req && wait_at_lim_s)) begin
            cpu_gnt_s = 1'b1;
          end else if (dma_req) begin
            dma_gnt_s = 1'b1;
            if (dma_lock) begin
              state_nxt_s = DMA_OWN;
              burst_nxt_s = BCW'(1);
            end else begin
              state_nxt_s = CPU_OWN;
            end
          end else begin
            state_nxt_s = CPU_OWN;
          end
        end
        DMA_OWN: begin
          dma_gnt_s = dma_req & ~forced_s;
          if (forced_s) begin
            // Burst cap reached with the CPU waiting: hand the slot over this cycle.
            cpu_gnt_s   = 1'b1;
            state_nxt_s = CPU_OWN;
            burst_nxt_s = '0;
          end else if (!dma_req) begin
            state_nxt_s = CPU_OWN;
            burst_nxt_s = '0;
          end else if (!dma_lock) begin
            state_nxt_s = CPU_OWN;
            burst_nxt_s = '0;
          end else begin
            burst_nxt_s = burst_at_max_s ? burst_cnt_r : burst_cnt_r + BCW'(1);
          end
        end
        default: begin
          state_nxt_s = CPU_OWN;
          burst_nxt_s = '0;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive cycles of a refused DMA request.
  always_comb begin
    wait_nxt_s = '0;
    if (Reset) begin
      wait_nxt_s = '0;
    end else if (dma_req && !dma_gnt_s) begin
      wait_nxt_s = wait_at_lim_s ? wait_cnt_r : wait_cnt_r + WCW'(1);
    end else begin
      wait_nxt_s = '0;
    end
  end

  // State, starvation and burst registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= CPU_OWN;
      wait_cnt_r  <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
      burst_cnt_r <= burst_nxt_s;
    end
  end

  // Memory bus mux follows the winner; an idle bus drives all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 4'b0000;
    if (cpu_gnt_s) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
    end else if (dma_gnt_s) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else begin
      mem_we    = 4'b0000;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt_s & ~Reset;
  assign dma_gnt   = dma_gnt_s;
  assign cpu_rdata = cpu_gnt_s ? mem_rdata : '0;
  assign dma_rdata = dma_gnt_s ? mem_rdata : '0;
  assign owner     = state_r;

endmodule
